// File: rtl/dbg_spi_host_if.sv
// rtl/dbg_spi_host_if.sv - request/response bus between a requester and dbg_spi_host
interface dbg_spi_host_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_read;
    logic [7:0]  req_cmd;
    logic [23:0] req_addr;
    logic        resp_valid;
    logic [7:0]  resp_data;
    logic [1:0]  resp_err;

    modport master (
        output req_valid, req_read, req_cmd, req_addr,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_read, req_cmd, req_addr,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/dbg_spi_host.sv
// rtl/dbg_spi_host.sv - debug SPI command-protocol master (mode 0, MSB first)
module dbg_spi_host #(
    parameter int CLK_DIV    = 4,   // clk cycles per SCLK half-period, >= 2
    parameter int BYTE_GAP   = 8,   // idle clk cycles between bytes, >= 1
    parameter int POLL_LIMIT = 64
) (
    input  logic          clk,
    input  logic          rst,
    dbg_spi_host_if.slave bus,
    output logic          spi_sclk,
    output logic          spi_mosi,
    input  logic          spi_miso,
    output logic          spi_ss
);
    localparam int TMAX = (2 * CLK_DIV > BYTE_GAP) ? 2 * CLK_DIV : BYTE_GAP;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int PW   = $clog2(POLL_LIMIT + 1);

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_PROTO   = 2'd2;
    localparam logic [7:0] CMD_READ    = 8'h01;
    localparam logic [7:0] ST_BUSY     = 8'hFE;
    localparam logic [7:0] ST_READY    = 8'hFF;

    typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_GAP, S_TAIL, S_HOLD} phase_e;
    typedef enum logic [3:0] {
        B_SCMD, B_SARG, B_RCMD, B_ADDR2, B_ADDR1, B_ADDR0, B_POLL0, B_POLL, B_DATA
    } step_e;

    phase_e        state_q, state_d;
    step_e         step_q, step_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [3:0]    half_q, half_d;
    logic [7:0]    tx_q, tx_d;
    logic [7:0]    rx_q, rx_d;
    logic [23:0]   addr_q, addr_d;
    logic [PW-1:0] poll_q, poll_d;
    logic          sclk_q, sclk_d;
    logic          ss_q, ss_d;
    logic [7:0]    pend_data_q, pend_data_d;
    logic [1:0]    pend_err_q, pend_err_d;
    logic [7:0]    resp_data_q, resp_data_d;
    logic [1:0]    resp_err_q, resp_err_d;
    logic          resp_valid_q, resp_valid_d;

    step_e         nxt_step;
    logic [7:0]    nxt_tx;
    logic          seq_done;
    logic [7:0]    fin_data;
    logic [1:0]    fin_err;
    logic [PW-1:0] poll_nxt;
    logic          half_end;

    // Byte sequencer: what follows the byte that just finished, judged on its rx.
    always_comb begin
        nxt_step = step_q;
        nxt_tx   = 8'h00;
        seq_done = 1'b0;
        fin_data = rx_q;
        fin_err  = ERR_OK;
        poll_nxt = poll_q;
        case (step_q)
            B_SCMD:  nxt_step = B_SARG;
            B_SARG:  seq_done = 1'b1;
            B_RCMD:  begin nxt_step = B_ADDR2; nxt_tx = addr_q[23:16]; end
            B_ADDR2: begin nxt_step = B_ADDR1; nxt_tx = addr_q[15:8];  end
            B_ADDR1: begin nxt_step = B_ADDR0; nxt_tx = addr_q[7:0];   end
            B_ADDR0: nxt_step = B_POLL0;
            B_POLL0: nxt_step = B_POLL;
            B_POLL: begin
                poll_nxt = poll_q + 1'b1;
                if (rx_q == ST_READY) begin
                    nxt_step = B_DATA;
                end else if (rx_q == ST_BUSY) begin
                    if (poll_nxt == PW'(POLL_LIMIT)) begin
                        seq_done = 1'b1;
                        fin_err  = ERR_TIMEOUT;
                    end
                end else begin
                    seq_done = 1'b1;
                    fin_err  = ERR_PROTO;
                end
            end
            B_DATA:  seq_done = 1'b1;
            default: begin seq_done = 1'b1; fin_err = ERR_PROTO; end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        tmr_d        = tmr_q;
        half_d       = half_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        addr_d       = addr_q;
        poll_d       = poll_q;
        sclk_d       = sclk_q;
        ss_d         = ss_q;
        pend_data_d  = pend_data_q;
        pend_err_d   = pend_err_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        resp_valid_d = 1'b0;
        half_end     = (tmr_q == TW'(CLK_DIV - 1));

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    state_d = S_SHIFT;
                    ss_d    = 1'b0;
                    tmr_d   = '0;
                    half_d  = 4'd0;
                    addr_d  = bus.req_addr;
                    poll_d  = '0;
                    tx_d    = bus.req_read ? CMD_READ : bus.req_cmd;
                    step_d  = bus.req_read ? B_RCMD : B_SCMD;
                end
            end
            // The first low half-period of each byte doubles as the SS lead-in.
            S_SHIFT: begin
                tmr_d = tmr_q + 1'b1;
                if (half_end) begin
                    tmr_d  = '0;
                    sclk_d = ~sclk_q;
                    half_d = half_q + 1'b1;
                    if (!sclk_q) begin
                        rx_d = {rx_q[6:0], spi_miso};
                    end else if (half_q != 4'd15) begin
                        tx_d = {tx_q[6:0], 1'b0};
                    end else begin
                        poll_d = poll_nxt;
                        if (seq_done) begin
                            state_d     = S_TAIL;
                            tx_d        = 8'h00;
                            pend_data_d = (fin_err == ERR_TIMEOUT) ? ST_BUSY : fin_data;
                            pend_err_d  = fin_err;
                        end else begin
                            state_d = S_GAP;
                            tx_d    = nxt_tx;
                            step_d  = nxt_step;
                        end
                    end
                end
            end
            S_GAP: begin
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == TW'(BYTE_GAP - 1)) begin
                    state_d = S_SHIFT;
                    tmr_d   = '0;
                    half_d  = 4'd0;
                end
            end
            S_TAIL: begin
                tmr_d = tmr_q + 1'b1;
                if (half_end) begin
                    state_d      = S_HOLD;
                    tmr_d        = '0;
                    ss_d         = 1'b1;
                    resp_valid_d = 1'b1;
                    resp_data_d  = pend_data_q;
                    resp_err_d   = pend_err_q;
                end
            end
            // Keeps SS high for a minimum time before the next request can start.
            S_HOLD: begin
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == TW'(2 * CLK_DIV - 1)) begin
                    state_d = S_IDLE;
                    tmr_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            step_q       <= B_SCMD;
            tmr_q        <= '0;
            half_q       <= 4'd0;
            tx_q         <= 8'h00;
            rx_q         <= 8'h00;
            addr_q       <= 24'h0;
            poll_q       <= '0;
            sclk_q       <= 1'b0;
            ss_q         <= 1'b1;
            pend_data_q  <= 8'h00;
            pend_err_q   <= ERR_OK;
            resp_data_q  <= 8'h00;
            resp_err_q   <= ERR_OK;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            tmr_q        <= tmr_d;
            half_q       <= half_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            addr_q       <= addr_d;
            poll_q       <= poll_d;
            sclk_q       <= sclk_d;
            ss_q         <= ss_d;
            pend_data_q  <= pend_data_d;
            pend_err_q   <= pend_err_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign spi_sclk       = sclk_q;
    assign spi_mosi       = tx_q[7];
    assign spi_ss         = ss_q;
    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_dbg_spi_host.sv
// tb/tb_dbg_spi_host.sv - directed bench for dbg_spi_host with a table-driven SPI slave
module tb_dbg_spi_host;
    localparam int CD = 4;
    localparam int BG = 8;
    localparam int PL = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spi_sclk, spi_mosi, spi_ss;
    logic spi_miso = 1'b0;

    dbg_spi_host_if bus ();

    dbg_spi_host #(.CLK_DIV(CD), .BYTE_GAP(BG), .POLL_LIMIT(PL)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_ss   (spi_ss)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] reply   [0:15];
    logic [7:0] mlog    [0:15];
    logic [7:0] exp_rd  [0:9];

    int cyc = 0, n_frames = 0, n_resp = 0, n_bytes = 0, bit_cnt = 0;
    int ss_high_run = 0, min_ss_high = 1000;
    int t_fall = 0, t_last_fall = 0, lead_cyc = 0, tail_cyc = 0;
    logic first_rise = 1'b0;
    logic ss_prev = 1'b1, sclk_prev = 1'b0;
    logic [7:0] s_tx = 8'h00, s_rx = 8'h00;

    // Mode-0 slave: miso set after SCLK falls, mosi captured after SCLK rises.
    always @(negedge clk) begin
        cyc++;
        if (bus.resp_valid) n_resp++;
        if (spi_ss) begin
            if (!ss_prev) tail_cyc = cyc - t_last_fall;
            ss_high_run++;
        end else if (ss_prev) begin
            if (n_frames > 0 && ss_high_run < min_ss_high) min_ss_high = ss_high_run;
            ss_high_run = 0;
            n_frames++;
            t_fall     = cyc;
            n_bytes    = 0;
            bit_cnt    = 0;
            first_rise = 1'b1;
            s_tx       = reply[0];
            spi_miso   = s_tx[7];
        end else begin
            if (spi_sclk && !sclk_prev) begin
                if (first_rise) lead_cyc = cyc - t_fall;
                first_rise = 1'b0;
                s_rx = {s_rx[6:0], spi_mosi};
                bit_cnt++;
            end
            if (!spi_sclk && sclk_prev) begin
                t_last_fall = cyc;
                if (bit_cnt == 8) begin
                    if (n_bytes < 16) mlog[n_bytes] = s_rx;
                    n_bytes++;
                    bit_cnt = 0;
                    s_tx = (n_bytes < 16) ? reply[n_bytes] : 8'h00;
                end else begin
                    s_tx = {s_tx[6:0], 1'b0};
                end
                spi_miso = s_tx[7];
            end
        end
        ss_prev   = spi_ss;
        sclk_prev = spi_sclk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input string tag, input logic rd, input logic [7:0] cmd,
                            input logic [23:0] addr);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_read  = rd;
        bus.req_cmd   = cmd;
        bus.req_addr  = addr;
        for (int i = 0; i < 200 && !bus.req_ready; i++) @(negedge clk);
        check({tag, "_accept"}, bus.req_ready, 1'b1);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string tag);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.resp_valid) break;
        end
        check({tag, "_resp_valid"}, bus.resp_valid, 1'b1);
        check({tag, "_ss_at_resp"}, spi_ss, 1'b1);
    endtask

    task automatic check_ready(input string tag);
        int k;
        k = 0;
        while (!bus.req_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_ready_latency"}, k, 2 * CD);
    endtask

    int f0, r0;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_read  = 1'b0;
        bus.req_cmd   = 8'h00;
        bus.req_addr  = 24'h0;
        for (int i = 0; i < 16; i++) reply[i] = 8'h00;
        repeat (4) @(negedge clk);
        check("rst_ss", spi_ss, 1'b1);
        check("rst_sclk", spi_sclk, 1'b0);
        check("rst_mosi", spi_mosi, 1'b0);
        check("rst_ready", bus.req_ready, 1'b1);
        check("rst_resp_valid", bus.resp_valid, 1'b0);
        check("rst_resp_data", bus.resp_data, 8'h00);
        check("rst_resp_err", bus.resp_err, 2'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Echo
        reply[1] = 8'hCC;
        f0 = n_frames; r0 = n_resp;
        send_req("echo", 1'b0, 8'hCC, 24'h0);
        wait_resp("echo");
        check("echo_data", bus.resp_data, 8'hCC);
        check("echo_err", bus.resp_err, 2'd0);
        check_ready("echo");
        check("echo_bytes", n_bytes, 2);
        check("echo_mosi0", mlog[0], 8'hCC);
        check("echo_mosi1", mlog[1], 8'h00);
        check("echo_frames", n_frames - f0, 1);
        check("echo_resp_cnt", n_resp - r0, 1);
        check("echo_lead", lead_cyc, CD);
        check("echo_tail", tail_cyc, CD);

        // LED toggle
        reply[1] = 8'hAB;
        send_req("led", 1'b0, 8'h02, 24'h0);
        wait_resp("led");
        check("led_data", bus.resp_data, 8'hAB);
        check("led_err", bus.resp_err, 2'd0);
        check("led_mosi0", mlog[0], 8'h02);
        check_ready("led");

        // Flash read, busy for 3 polls then ready on the last allowed poll
        for (int i = 0; i < 16; i++) reply[i] = 8'h00;
        reply[1] = 8'h37; reply[2] = 8'h37; reply[3] = 8'h37; reply[4] = 8'h37;
        reply[5] = 8'hFE; reply[6] = 8'hFE; reply[7] = 8'hFE; reply[8] = 8'hFF;
        reply[9] = 8'h5A;
        exp_rd[0] = 8'h01; exp_rd[1] = 8'h12; exp_rd[2] = 8'h34; exp_rd[3] = 8'h56;
        for (int i = 4; i < 10; i++) exp_rd[i] = 8'h00;
        send_req("rd", 1'b1, 8'h00, 24'h123456);
        wait_resp("rd");
        check("rd_data", bus.resp_data, 8'h5A);
        check("rd_err", bus.resp_err, 2'd0);
        check("rd_bytes", n_bytes, 10);
        for (int i = 0; i < 10; i++) check($sformatf("rd_mosi%0d", i), mlog[i], exp_rd[i]);
        check_ready("rd");

        // Timeout after PL busy polls
        reply[8] = 8'hFE; reply[9] = 8'hFF;
        send_req("tmo", 1'b1, 8'h00, 24'hABCDEF);
        wait_resp("tmo");
        check("tmo_err", bus.resp_err, 2'd1);
        check("tmo_data", bus.resp_data, 8'hFE);
        check("tmo_bytes", n_bytes, 9);
        check("tmo_mosi1", mlog[1], 8'hAB);
        check("tmo_mosi3", mlog[3], 8'hEF);
        check_ready("tmo");

        // Protocol error on first poll
        reply[5] = 8'h37;
        send_req("perr", 1'b1, 8'h00, 24'h000001);
        wait_resp("perr");
        check("perr_err", bus.resp_err, 2'd2);
        check("perr_data", bus.resp_data, 8'h37);
        check("perr_bytes", n_bytes, 6);
        check_ready("perr");

        // Reset in the middle of the ADDR1 byte
        for (int i = 0; i < 16; i++) reply[i] = 8'h00;
        r0 = n_resp;
        send_req("rstmid", 1'b1, 8'h00, 24'h123456);
        for (int i = 0; i < 2000 && !(n_bytes == 2 && bit_cnt == 3); i++) @(negedge clk);
        check("rstmid_reached", n_bytes * 16 + bit_cnt, 2 * 16 + 3);
        check("rstmid_ss_low", spi_ss, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_ss", spi_ss, 1'b1);
        check("rstmid_sclk", spi_sclk, 1'b0);
        check("rstmid_ready", bus.req_ready, 1'b1);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rstmid_no_resp", n_resp - r0, 0);
        check("rstmid_resp_data", bus.resp_data, 8'h00);
        reply[1] = 8'hCC;
        send_req("echo2", 1'b0, 8'hCC, 24'h0);
        wait_resp("echo2");
        check("echo2_data", bus.resp_data, 8'hCC);
        check("echo2_bytes", n_bytes, 2);
        check_ready("echo2");

        // Back-to-back with req_valid held high
        reply[1] = 8'h5C;
        f0 = n_frames; r0 = n_resp;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_read  = 1'b0;
        bus.req_cmd   = 8'h5C;
        for (int k = 0; k < 3; k++) begin
            wait_resp($sformatf("b2b%0d", k));
            check($sformatf("b2b%0d_data", k), bus.resp_data, 8'h5C);
        end
        bus.req_valid = 1'b0;
        repeat (30) @(negedge clk);
        check("b2b_frames", n_frames - f0, 3);
        check("b2b_resp_cnt", n_resp - r0, 3);
        check("b2b_ss_high_min", min_ss_high >= 2 * CD, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dbg_spi_host.md
Name: dbg_spi_host

Overview:
- SPI master: initiator side of the board's debug SPI command protocol; drives the debug SPI slave on the FPGA.
- Runs on the host/test FPGA.
- Turns single requests (short command, or flash read with busy polling) into full SPI byte sequences.
- Returns one response byte plus an error code.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period; must be ≥2.
- BYTE_GAP, 8: idle clk cycles between bytes with SS held low. Gives the slave time to load its next reply.
- POLL_LIMIT, 64: maximum status polls before a flash read times out.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request strobe; accepted when req_valid && req_ready
- req_ready  out  1  idle, able to accept a request
- req_read  in  1  1 = flash read, 0 = short command
- req_cmd  in  8  command byte for a short command
- req_addr  in  24  flash address for a flash read
- resp_valid  out  1  one-cycle pulse, response available
- resp_data  out  8  response byte; held until the next resp_valid
- resp_err  out  2  0 = ok, 1 = poll timeout, 2 = protocol error
- spi_sclk  out  1  SPI clock, idles low
- spi_mosi  out  1  master out
- spi_miso  in  1  master in
- spi_ss  out  1  slave select, active low

Behaviour:
- Reset values: spi_ss=1, spi_sclk=0, spi_mosi=0, req_ready=1, resp_valid=0, resp_data=0, resp_err=0, all counters 0. Reset is synchronous.
- Reset mid-transaction: aborts on the next edge; spi_ss returns to 1 and spi_sclk to 0; no resp_valid is issued.
- SPI framing: mode 0, MSB first.
  - spi_mosi changes on the clk cycle SCLK falls, and before the first rise.
  - spi_miso is sampled on the clk cycle SCLK rises.
  - Each byte is 8 SCLK periods, i.e. 16*CLK_DIV clk cycles.
- Bus timing: spi_ss stays low for the whole transaction. Lead-in of CLK_DIV cycles with SS low before the first SCLK edge. BYTE_GAP cycles between bytes. CLK_DIV cycles after the last edge before SS rises.
- Acceptance: on req_valid && req_ready, req_cmd, req_addr and req_read are latched and req_ready drops.
  - req_valid while busy is ignored and has no effect.
- Reply semantics: the slave's reply to byte N is clocked out during byte N+1. The rx byte of byte N reflects byte N-1.
- Short command (req_read=0): send req_cmd, then send 0x00. resp_data = rx of the second byte; resp_err=0. Two bytes total.
- Flash read (req_read=1), sequencer states:
  - CMD: send 0x01; rx ignored.
  - ADDR2/ADDR1/ADDR0: send req_addr[23:16], [15:8], [7:0]; rx ignored.
  - POLL0: send 0x00; rx ignored (stale byte).
  - POLL: send 0x00 and increment the poll counter.
    - rx 0xFE: stay in POLL.
    - rx 0xFF: go to DATA.
    - Any other rx: finish with resp_err=2, resp_data = offending byte.
    - Counter reaching POLL_LIMIT with rx 0xFE: finish with resp_err=1, resp_data=0xFE.
    - rx 0xFF on the final allowed poll goes to DATA; this is not a timeout.
  - DATA: send 0x00; resp_data = rx; resp_err=0.
- Completion: resp_valid pulses on the cycle spi_ss returns high. req_ready returns high 2*CLK_DIV cycles later, which guarantees a minimum SS-high time.
- Poll counter width: clog2(POLL_LIMIT+1); no wrap.
- No pipelining: one transaction in flight.

Test Plan:
- Echo: short cmd 0xCC, slave model per protocol. MOSI bytes CC,00 under one SS-low window; resp_data=0xCC, resp_err=0, one resp_valid pulse.
- LED toggle: short cmd 0x02. Model returns 0xAB on the second byte; resp_data=0xAB.
- Flash read: addr 0x123456, model busy for 3 polls, data 0x5A. MOSI = 01,12,34,56,00 (POLL0),00×3 (FE),00 (FF),00 (data); resp_data=0x5A, resp_err=0.
- Timeout: POLL_LIMIT=4, model always 0xFE. resp_err=1 and resp_data=0xFE exactly after the 4th POLL byte; spi_ss high; req_ready returns.
- Protocol error: model replies 0x37 on the first POLL. resp_err=2, resp_data=0x37, no further bytes sent.
- Reset mid-ADDR1 byte: spi_ss=1 and spi_sclk=0 on the next edge; no resp_valid. A following echo request completes normally.
- Back-to-back: req_valid held high continuously. Spi_ss stays high ≥2*CLK_DIV cycles between transactions; requests made while busy are not double-accepted.
